// File: rtl/pit_io_frontend.sv
// pit_io_frontend
// Bus-side front end for a three-channel 8254 PIT model: decodes I/O accesses
// to ports 0x40-0x43 into registered one-cycle per-channel strobes, returns
// channel read data, and derives the nominal counter clock from the system
// clock with a fractional accumulator.

module pit_io_frontend #(
    parameter int unsigned CLK_HZ = 30000000,
    parameter int unsigned PIT_HZ = 1193182
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] io_address,
    input  logic       io_read,
    input  logic       io_write,
    input  logic [7:0] io_writedata,
    output logic       io_waitrequest,
    output logic [7:0] io_readdata,
    output logic       io_readdatavalid,
    input  logic [7:0] ch_data_out0,
    input  logic [7:0] ch_data_out1,
    input  logic [7:0] ch_data_out2,
    output logic [7:0] ch_data_in,
    output logic [2:0] ch_set_control_mode,
    output logic [2:0] ch_latch_count,
    output logic [2:0] ch_latch_status,
    output logic [2:0] ch_write,
    output logic [2:0] ch_read,
    output logic       pit_clock
);

    // Accumulator increment and wrap value; two toggles per counter period.
    localparam logic [31:0] STEP  = 32'(2 * PIT_HZ);
    localparam logic [31:0] LIMIT = 32'(CLK_HZ);

    logic       busy_q,      busy_d;
    logic [7:0] readdata_q,  readdata_d;
    logic       rdvalid_q,   rdvalid_d;
    logic [7:0] datain_q,    datain_d;
    logic [2:0] mode_q,      mode_d;
    logic [2:0] latchCnt_q,  latchCnt_d;
    logic [2:0] latchStat_q, latchStat_d;
    logic [2:0] chWrite_q,   chWrite_d;
    logic [2:0] chRead_q,    chRead_d;
    logic [31:0] acc_q,      acc_d;
    logic        pitClk_q,   pitClk_d;
    logic [31:0] accSum;
    logic        accept;

    // Selects one of the three channels; code 3 selects none.
    function automatic logic [2:0] oneHot(input logic [1:0] sel);
        case (sel)
            2'd0:    oneHot = 3'b001;
            2'd1:    oneHot = 3'b010;
            2'd2:    oneHot = 3'b100;
            default: oneHot = 3'b000;
        endcase
    endfunction

    // The busy cycle after every accept guarantees a low cycle between strobes.
    assign accept = (io_read | io_write) & ~busy_q;

    // Decode an accepted access into next-cycle strobes and read data.
    always_comb begin
        busy_d      = accept;
        readdata_d  = readdata_q;
        rdvalid_d   = 1'b0;
        datain_d    = datain_q;
        mode_d      = 3'b000;
        latchCnt_d  = 3'b000;
        latchStat_d = 3'b000;
        chWrite_d   = 3'b000;
        chRead_d    = 3'b000;
        if (accept) begin
            if (io_write) begin
                datain_d = io_writedata;
                if (io_address != 2'd3) begin
                    chWrite_d = oneHot(io_address);
                end else if (io_writedata[7:6] != 2'd3) begin
                    if (io_writedata[5:4] == 2'b00) begin
                        latchCnt_d = oneHot(io_writedata[7:6]);
                    end else begin
                        mode_d = oneHot(io_writedata[7:6]);
                    end
                end else begin
                    if (!io_writedata[5]) begin
                        latchCnt_d = io_writedata[3:1];
                    end
                    if (!io_writedata[4]) begin
                        latchStat_d = io_writedata[3:1];
                    end
                end
            end else begin
                rdvalid_d = 1'b1;
                chRead_d  = oneHot(io_address);
                case (io_address)
                    2'd0:    readdata_d = ch_data_out0;
                    2'd1:    readdata_d = ch_data_out1;
                    2'd2:    readdata_d = ch_data_out2;
                    default: readdata_d = 8'hFF;
                endcase
            end
        end
    end

    // Fractional divider: toggle whenever the accumulator passes the system rate.
    always_comb begin
        accSum   = acc_q + STEP;
        acc_d    = accSum;
        pitClk_d = pitClk_q;
        if (accSum >= LIMIT) begin
            acc_d    = accSum - LIMIT;
            pitClk_d = ~pitClk_q;
        end
    end

    // All bus-side and clock-generator state, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q      <= 1'b0;
            readdata_q  <= 8'h00;
            rdvalid_q   <= 1'b0;
            datain_q    <= 8'h00;
            mode_q      <= 3'b000;
            latchCnt_q  <= 3'b000;
            latchStat_q <= 3'b000;
            chWrite_q   <= 3'b000;
            chRead_q    <= 3'b000;
            acc_q       <= 32'd0;
            pitClk_q    <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            readdata_q  <= readdata_d;
            rdvalid_q   <= rdvalid_d;
            datain_q    <= datain_d;
            mode_q      <= mode_d;
            latchCnt_q  <= latchCnt_d;
            latchStat_q <= latchStat_d;
            chWrite_q   <= chWrite_d;
            chRead_q    <= chRead_d;
            acc_q       <= acc_d;
            pitClk_q    <= pitClk_d;
        end
    end

    assign io_waitrequest      = busy_q;
    assign io_readdata         = readdata_q;
    assign io_readdatavalid    = rdvalid_q;
    assign ch_data_in          = datain_q;
    assign ch_set_control_mode = mode_q;
    assign ch_latch_count      = latchCnt_q;
    assign ch_latch_status     = latchStat_q;
    assign ch_write            = chWrite_q;
    assign ch_read             = chRead_q;
    assign pit_clock           = pitClk_q;

endmodule
